vec_wb_merge_unit: RTL and testbench

// Writer side of the vector register file write port. Accepts one result per valid/ready handshake.

---
 rtl/vec_wb_pkg.sv | 53 +++++
 rtl/vec_elem_merge.sv | 55 +++++
 rtl/vec_wb_merge_unit.sv | 180 ++++++++++++++++++
 tb/tb_vec_wb_merge_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_wb_pkg.sv
// Shared types and constants for the vector write-back merge unit.
package vec_wb_pkg;

    localparam int VLEN_DEF       = 512;
    localparam int DATA_WIDTH_DEF = 8 * VLEN_DEF;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int TIMEOUT_DEF    = 16;
    localparam int NUM_VREGS      = 32;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_RD   = 2'd1,
        WB_WR   = 2'd2,
        WB_WAIT = 2'd3
    } wb_state_e;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } sew_e;

    // One-hot LMUL encodings; the numeric value of each equals the register count.
    localparam logic [3:0] LMUL1 = 4'b0001;
    localparam logic [3:0] LMUL2 = 4'b0010;
    localparam logic [3:0] LMUL4 = 4'b0100;
    localparam logic [3:0] LMUL8 = 4'b1000;

    // True when the destination group cannot be written: bad LMUL encoding,
    // misaligned or overflowing group, or a masked op overwriting its own mask.
    function automatic logic wb_illegal(input logic [4:0] vd,
                                        input logic [3:0] lmul,
                                        input logic       vm,
                                        input logic       mask_dst);
        logic [5:0] vd6;
        logic [5:0] l6;
        logic       bad;
        vd6 = {1'b0, vd};
        l6  = {2'b00, lmul};
        bad = 1'b0;
        if (!(lmul == LMUL1 || lmul == LMUL2 || lmul == LMUL4 || lmul == LMUL8))
            bad = 1'b1;
        if ((vd6 & (l6 - 6'd1)) != 6'd0)
            bad = 1'b1;
        if ((vd6 + l6) > 6'(NUM_VREGS))
            bad = 1'b1;
        if (!vm && (vd == 5'd0) && !mask_dst)
            bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/vec_elem_merge.sv
// Combinational byte-lane merge: each lane takes the new result when its
// element is a body element that is active under the mask, else the old value.
import vec_wb_pkg::*;

module vec_elem_merge #(
    parameter int VLEN       = VLEN_DEF,
    parameter int DATA_WIDTH = 8 * VLEN,
    parameter int VL_WIDTH   = $clog2(DATA_WIDTH / 8) + 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] old,
    input  logic [VLEN-1:0]       v0,
    input  logic                  vm,
    input  logic [1:0]            sew,
    input  logic [VL_WIDTH-1:0]   vl,
    input  logic [3:0]            lmul,
    output logic [DATA_WIDTH-1:0] merged
);

    localparam int NBYTES = DATA_WIDTH / 8;

    // Bytes belonging to the group; lanes past it (and their mask bits) are left untouched.
    logic [15:0] grp_bytes;
    assign grp_bytes = 16'(lmul) * 16'(VLEN / 8);

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            localparam logic [VL_WIDTH-1:0] E8  = VL_WIDTH'(gi);
            localparam logic [VL_WIDTH-1:0] E16 = VL_WIDTH'(gi / 2);
            localparam logic [VL_WIDTH-1:0] E32 = VL_WIDTH'(gi / 4);
            localparam logic [VL_WIDTH-1:0] E64 = VL_WIDTH'(gi / 8);
            localparam logic [15:0]         B16 = 16'(gi);

            logic act;
            logic in_grp;

            assign in_grp = (B16 < grp_bytes);

            // Element index of this lane depends on SEW; mask bit is that element's v0 bit.
            always_comb begin
                act = 1'b0;
                case (sew)
                    SEW8:    act = (E8  < vl) && (vm || v0[gi]);
                    SEW16:   act = (E16 < vl) && (vm || v0[gi / 2]);
                    SEW32:   act = (E32 < vl) && (vm || v0[gi / 4]);
                    default: act = (E64 < vl) && (vm || v0[gi / 8]);
                endcase
            end

            assign merged[gi*8 +: 8] = (in_grp && act) ? data[gi*8 +: 8] : old[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/vec_wb_merge_unit.sv
// Vector register-file write-back: captures one result, merges it with the
// old destination group, issues a single write and reports done/error.
import vec_wb_pkg::*;

module vec_wb_merge_unit #(
    parameter int VLEN       = VLEN_DEF,
    parameter int DATA_WIDTH = 8 * VLEN,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int VL_WIDTH   = $clog2(DATA_WIDTH / 8) + 1,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic [ADDR_WIDTH-1:0] res_vd,
    input  logic                  res_vm,
    input  logic [1:0]            res_sew,
    input  logic [VL_WIDTH-1:0]   res_vl,
    input  logic [3:0]            res_lmul,
    input  logic                  res_mask_dst,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [3:0]            rf_lmul,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  rf_wr_en,
    output logic                  rf_mask_wr_en,
    input  logic [DATA_WIDTH-1:0] rf_dst_data,
    input  logic [VLEN-1:0]       rf_v0_mask,
    input  logic                  rf_data_written,
    input  logic                  rf_wrong_addr,
    output logic                  busy,
    output logic                  wb_done,
    output logic                  wb_error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    wb_state_e             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_en_q, mwr_en_q, ready_q;

    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] vd_q;
    logic                  vm_q;
    logic [1:0]            sew_q;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [3:0]            lmul_q;
    logic                  mdst_q;

    logic                  accept;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] merged;

    assign accept  = (state_q == WB_IDLE) && res_valid && ready_q;
    assign illegal = wb_illegal(5'(vd_q), lmul_q, vm_q, mdst_q);

    vec_elem_merge #(
        .VLEN       (VLEN),
        .DATA_WIDTH (DATA_WIDTH),
        .VL_WIDTH   (VL_WIDTH)
    ) u_merge (
        .data   (data_q),
        .old    (rf_dst_data),
        .v0     (rf_v0_mask),
        .vm     (vm_q),
        .sew    (sew_q),
        .vl     (vl_q),
        .lmul   (lmul_q),
        .merged (merged)
    );

    // Next-state logic; acknowledge is looked at from the WR cycle onward, error beats done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wdata_d = wdata_q;
        case (state_q)
            WB_IDLE: begin
                if (accept)
                    state_d = WB_RD;
            end
            WB_RD: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    wdata_d = mdst_q ? data_q : merged;
                    state_d = WB_WR;
                end
            end
            WB_WR: begin
                cnt_d = '0;
                if (rf_wrong_addr) begin
                    err_d   = 1'b1;
                    state_d = WB_IDLE;
                end else if (rf_data_written) begin
                    done_d  = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    state_d = WB_WAIT;
                end
            end
            default: begin
                if (rf_wrong_addr) begin
                    err_d   = 1'b1;
                    state_d = WB_IDLE;
                end else if (rf_data_written) begin
                    done_d  = 1'b1;
                    state_d = WB_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = WB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Control registers; strobes are registered so reset removes them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= WB_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            mwr_en_q <= 1'b0;
            ready_q  <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wr_en_q  <= (state_d == WB_WR) && !mdst_q;
            mwr_en_q <= (state_d == WB_WR) && mdst_q;
            ready_q  <= (state_d == WB_IDLE);
            wdata_q  <= wdata_d;
        end
    end

    // Capture the result fields on the accepting handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            vd_q   <= '0;
            vm_q   <= 1'b0;
            sew_q  <= 2'd0;
            vl_q   <= '0;
            lmul_q <= 4'd0;
            mdst_q <= 1'b0;
        end else if (accept) begin
            data_q <= res_data;
            vd_q   <= res_vd;
            vm_q   <= res_vm;
            sew_q  <= res_sew;
            vl_q   <= res_vl;
            lmul_q <= res_lmul;
            mdst_q <= res_mask_dst;
        end
    end

    assign res_ready     = ready_q;
    assign rf_waddr      = vd_q;
    assign rf_lmul       = lmul_q;
    assign rf_wdata      = wdata_q;
    assign rf_wr_en      = wr_en_q;
    assign rf_mask_wr_en = mwr_en_q;
    assign busy          = (state_q != WB_IDLE);
    assign wb_done       = done_q;
    assign wb_error      = err_q;

endmodule

// File: tb/tb_vec_wb_merge_unit.sv
// Bench for vec_wb_merge_unit: directed scenarios plus randomized results
// checked against a byte-level reference model of the merge rules.
module tb_vec_wb_merge_unit;

    localparam int VLEN    = 512;
    localparam int DW      = 8 * VLEN;
    localparam int VLW     = $clog2(DW / 8) + 1;
    localparam int TIMEOUT = 16;
    localparam int MAXK    = 30;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           res_valid = 1'b0;
    logic           res_ready;
    logic [DW-1:0]  res_data = '0;
    logic [4:0]     res_vd = '0;
    logic           res_vm = 1'b0;
    logic [1:0]     res_sew = '0;
    logic [VLW-1:0] res_vl = '0;
    logic [3:0]     res_lmul = '0;
    logic           res_mask_dst = 1'b0;
    logic [4:0]     rf_waddr;
    logic [3:0]     rf_lmul;
    logic [DW-1:0]  rf_wdata;
    logic           rf_wr_en;
    logic           rf_mask_wr_en;
    logic [DW-1:0]  rf_dst_data = '0;
    logic [VLEN-1:0] rf_v0_mask = '0;
    logic           rf_data_written = 1'b0;
    logic           rf_wrong_addr = 1'b0;
    logic           busy;
    logic           wb_done;
    logic           wb_error;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    typedef struct {
        int            wr_n;
        int            mwr_n;
        int            done_k;
        int            err_k;
        int            done_n;
        int            err_n;
        int            rb_n;
        logic          busy_p;
        logic          ready_p;
        logic [DW-1:0] wdata;
    } obs_t;

    always #5 clk = ~clk;

    vec_wb_merge_unit #(
        .VLEN       (VLEN),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (5),
        .VL_WIDTH   (VLW),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .res_vd          (res_vd),
        .res_vm          (res_vm),
        .res_sew         (res_sew),
        .res_vl          (res_vl),
        .res_lmul        (res_lmul),
        .res_mask_dst    (res_mask_dst),
        .rf_waddr        (rf_waddr),
        .rf_lmul         (rf_lmul),
        .rf_wdata        (rf_wdata),
        .rf_wr_en        (rf_wr_en),
        .rf_mask_wr_en   (rf_mask_wr_en),
        .rf_dst_data     (rf_dst_data),
        .rf_v0_mask      (rf_v0_mask),
        .rf_data_written (rf_data_written),
        .rf_wrong_addr   (rf_wrong_addr),
        .busy            (busy),
        .wb_done         (wb_done),
        .wb_error        (wb_error)
    );

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic int lmul_regs(input logic [3:0] l);
        case (l)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_legal(input int vd, input logic [3:0] l, input logic vm, input logic mdst);
        int regs;
        regs = lmul_regs(l);
        if (regs == 0) return 1'b0;
        if (vd % regs != 0) return 1'b0;
        if (vd + regs > 32) return 1'b0;
        if (!vm && vd == 0 && !mdst) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [DW-1:0] model_wdata(input logic [DW-1:0] data, input logic [DW-1:0] dst,
                                                  input logic [VLEN-1:0] v0, input logic vm,
                                                  input int sew_code, input int vl, input int regs,
                                                  input logic mdst);
        logic [DW-1:0] r;
        int ebytes, e;
        if (mdst) return data;
        r = dst;
        ebytes = 1 << sew_code;
        for (int b = 0; b < DW / 8; b++) begin
            e = b / ebytes;
            if (b < regs * (VLEN / 8) && e < vl && (vm || v0[e]))
                r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic int first_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < DW / 8; i++)
            if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
        return -1;
    endfunction

    // ---------------- transaction driver / observer ----------------
    // Offers one result, then samples one line per cycle; sample k follows the k-th edge after accept.
    task automatic run_txn(input logic [DW-1:0] data, input logic [DW-1:0] dst, input logic [VLEN-1:0] v0,
                           input logic [4:0] vd, input logic vm, input logic [1:0] sew, input int vl,
                           input logic [3:0] lmul, input logic mdst, input int ack_d, input int wrong_d,
                           output obs_t o);
        int wr_k, waitk, fin;
        o.wr_n = 0; o.mwr_n = 0; o.done_k = -1; o.err_k = -1; o.done_n = 0; o.err_n = 0;
        o.rb_n = 0; o.busy_p = 1'bx; o.ready_p = 1'bx; o.wdata = '0;
        wr_k = -1;
        @(negedge clk);
        res_data = data; rf_dst_data = dst; rf_v0_mask = v0; res_vd = vd; res_vm = vm;
        res_sew = sew; res_vl = VLW'(vl); res_lmul = lmul; res_mask_dst = mdst; res_valid = 1'b1;
        waitk = 0;
        while (!res_ready && waitk < 10) begin
            @(negedge clk);
            waitk++;
        end
        n_cmp++;
        if (!res_ready) begin
            n_fail++;
            $display("FAIL accept_bound: res_ready=%b after %0d cycles, required 1", res_ready, waitk);
            res_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int k = 0; k < MAXK; k++) begin
            @(negedge clk);
            if (k == 0) res_valid = 1'b0;
            if (rf_wr_en)      begin o.wr_n++;  o.wdata = rf_wdata; wr_k = k; end
            if (rf_mask_wr_en) begin o.mwr_n++; o.wdata = rf_wdata; wr_k = k; end
            if (busy && res_ready) o.rb_n++;
            if (wb_done) begin
                o.done_n++;
                if (o.done_k < 0 && o.err_k < 0) begin o.busy_p = busy; o.ready_p = res_ready; end
                if (o.done_k < 0) o.done_k = k;
            end
            if (wb_error) begin
                o.err_n++;
                if (o.done_k < 0 && o.err_k < 0) begin o.busy_p = busy; o.ready_p = res_ready; end
                if (o.err_k < 0) o.err_k = k;
            end
            rf_data_written = (wr_k >= 0 && ack_d >= 0 && k == wr_k + ack_d);
            rf_wrong_addr   = (wr_k >= 0 && wrong_d >= 0 && k == wr_k + wrong_d);
            fin = (o.done_k >= 0) ? o.done_k : o.err_k;
            if (fin >= 0 && k >= fin + 2) break;
        end
        rf_data_written = 1'b0;
        rf_wrong_addr   = 1'b0;
        n_txn++;
        $display("txn %0d: vd=%0d lmul=%b sew=%0d vl=%0d vm=%b mdst=%b wr=%0d mwr=%0d done@%0d err@%0d",
                 n_txn, vd, lmul, sew, vl, vm, mdst, o.wr_n, o.mwr_n, o.done_k, o.err_k);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (res_ready !== 1'b0)     begin n_fail++; $display("FAIL rst_ready: got %b want 0", res_ready); end
        n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (rf_wr_en !== 1'b0 || rf_mask_wr_en !== 1'b0)
                                             begin n_fail++; $display("FAIL rst_strobes: got %b%b want 00", rf_wr_en, rf_mask_wr_en); end
        n_cmp++; if (wb_done !== 1'b0 || wb_error !== 1'b0)
                                             begin n_fail++; $display("FAIL rst_pulses: got %b%b want 00", wb_done, wb_error); end
        n_cmp++; if (rf_wdata !== '0 || rf_waddr !== 5'd0 || rf_lmul !== 4'd0)
                                             begin n_fail++; $display("FAIL rst_rf_outs: waddr=%0d lmul=%b want 0", rf_waddr, rf_lmul); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (res_ready !== 1'b1)     begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", res_ready); end
    endtask

    task automatic test_unmasked();
        obs_t o;
        logic [DW-1:0] d, dst, exp;
        logic [VLEN-1:0] a5;
        d = {(DW/8){8'hA5}};
        dst = rnd_vec();
        a5 = {(VLEN/8){8'hA5}};
        exp = model_wdata(d, dst, '0, 1'b1, 2, 16, 1, 1'b0);
        run_txn(d, dst, '0, 5'd4, 1'b1, 2'b10, 16, 4'b0001, 1'b0, 1, -1, o);
        n_cmp++; if (o.wr_n !== 1 || o.mwr_n !== 0) begin n_fail++; $display("FAIL unm_strobes: wr=%0d mwr=%0d want 1/0", o.wr_n, o.mwr_n); end
        n_cmp++; if (o.wdata[VLEN-1:0] !== a5) begin n_fail++; $display("FAIL unm_group_a5: first bad byte %0d", first_diff({{(DW-VLEN){1'b0}}, o.wdata[VLEN-1:0]}, {{(DW-VLEN){1'b0}}, a5})); end
        n_cmp++; if (o.wdata !== exp) begin n_fail++; $display("FAIL unm_wdata: first bad byte %0d", first_diff(o.wdata, exp)); end
        n_cmp++; if (o.done_k !== 3 || o.done_n !== 1 || o.err_n !== 0)
                 begin n_fail++; $display("FAIL unm_done: done@%0d n=%0d err=%0d want done@3 n=1 err=0", o.done_k, o.done_n, o.err_n); end
        n_cmp++; if (o.ready_p !== 1'b1 || o.rb_n !== 0)
                 begin n_fail++; $display("FAIL unm_ready: ready_at_done=%b ready_while_busy=%0d want 1/0", o.ready_p, o.rb_n); end
    endtask

    task automatic test_masked();
        obs_t o;
        logic [DW-1:0] d, dst, exp;
        logic [VLEN-1:0] v0;
        logic [63:0] low_exp;
        d = {(DW/8){8'hFF}};
        dst = {(DW/8){8'h11}};
        v0 = rnd_vec()[VLEN-1:0];
        v0[7:0] = 8'h55;
        low_exp = 64'h11FF_11FF_11FF_11FF;
        exp = model_wdata(d, dst, v0, 1'b0, 0, 8, 1, 1'b0);
        run_txn(d, dst, v0, 5'd8, 1'b0, 2'b00, 8, 4'b0001, 1'b0, 1, -1, o);
        n_cmp++; if (o.wdata[63:0] !== low_exp) begin n_fail++; $display("FAIL msk_body: got %h want %h", o.wdata[63:0], low_exp); end
        n_cmp++; if (o.wdata !== exp) begin n_fail++; $display("FAIL msk_tail: first bad byte %0d", first_diff(o.wdata, exp)); end
        n_cmp++; if (o.done_k !== 3) begin n_fail++; $display("FAIL msk_done: done@%0d want 3", o.done_k); end
    endtask

    task automatic test_illegal();
        obs_t o;
        logic [4:0] t_vd [5];
        logic [3:0] t_lm [5];
        logic       t_vm [5];
        t_vd = '{5'd3, 5'd0, 5'd28, 5'd5, 5'd16};
        t_lm = '{4'b0010, 4'b0001, 4'b1000, 4'b0011, 4'b0000};
        t_vm = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_txn(rnd_vec(), rnd_vec(), '1, t_vd[i], t_vm[i], 2'b01, 40, t_lm[i], 1'b0, 0, -1, o);
            n_cmp++; if (o.wr_n + o.mwr_n !== 0) begin n_fail++; $display("FAIL ill%0d_strobe: strobes=%0d want 0", i, o.wr_n + o.mwr_n); end
            n_cmp++; if (o.err_k !== 1 || o.err_n !== 1 || o.done_n !== 0)
                     begin n_fail++; $display("FAIL ill%0d_err: err@%0d n=%0d done=%0d want err@1 n=1 done=0", i, o.err_k, o.err_n, o.done_n); end
            n_cmp++; if (o.busy_p !== 1'b0) begin n_fail++; $display("FAIL ill%0d_busy: busy=%b at error, want 0", i, o.busy_p); end
        end
        // Top-aligned LMUL=8 group just fits.
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd24, 1'b1, 2'b11, 64, 4'b1000, 1'b0, 1, -1, o);
        n_cmp++; if (o.done_k !== 3 || o.wr_n !== 1) begin n_fail++; $display("FAIL edge_vd24: done@%0d wr=%0d want 3/1", o.done_k, o.wr_n); end
    endtask

    task automatic test_mask_dst();
        obs_t o;
        logic [DW-1:0] d;
        d = rnd_vec();
        run_txn(d, rnd_vec(), rnd_vec()[VLEN-1:0], 5'd0, 1'b0, 2'b00, 17, 4'b0001, 1'b1, 1, -1, o);
        n_cmp++; if (o.mwr_n !== 1 || o.wr_n !== 0) begin n_fail++; $display("FAIL mdst_strobes: mwr=%0d wr=%0d want 1/0", o.mwr_n, o.wr_n); end
        n_cmp++; if (o.wdata !== d) begin n_fail++; $display("FAIL mdst_wdata: first bad byte %0d", first_diff(o.wdata, d)); end
        n_cmp++; if (o.done_k !== 3) begin n_fail++; $display("FAIL mdst_done: done@%0d want 3", o.done_k); end
    endtask

    task automatic test_vl_bounds();
        obs_t o;
        logic [DW-1:0] d, dst, exp;
        d = rnd_vec();
        dst = rnd_vec();
        run_txn(d, dst, '1, 5'd8, 1'b1, 2'b01, 0, 4'b0100, 1'b0, 1, -1, o);
        n_cmp++; if (o.wdata !== dst) begin n_fail++; $display("FAIL vl0_wdata: first bad byte %0d", first_diff(o.wdata, dst)); end
        n_cmp++; if (o.done_k !== 3) begin n_fail++; $display("FAIL vl0_done: done@%0d want 3", o.done_k); end
        exp = model_wdata(d, dst, '0, 1'b1, 3, 1000, 8, 1'b0);
        run_txn(d, dst, '0, 5'd0, 1'b1, 2'b11, 1000, 4'b1000, 1'b0, 1, -1, o);
        n_cmp++; if (o.wdata !== exp) begin n_fail++; $display("FAIL vlmax_wdata: first bad byte %0d", first_diff(o.wdata, exp)); end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd2, 1'b1, 2'b00, 5, 4'b0010, 1'b0, -1, -1, o);
        n_cmp++; if (o.err_k !== 2 + TIMEOUT || o.err_n !== 1 || o.done_n !== 0)
                 begin n_fail++; $display("FAIL tmo_err: err@%0d n=%0d done=%0d want err@%0d n=1 done=0", o.err_k, o.err_n, o.done_n, 2 + TIMEOUT); end
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd2, 1'b1, 2'b00, 5, 4'b0010, 1'b0, 1, -1, o);
        n_cmp++; if (o.done_k !== 3 || o.err_n !== 0) begin n_fail++; $display("FAIL tmo_next: done@%0d err=%0d want 3/0", o.done_k, o.err_n); end
    endtask

    task automatic test_ack_variants();
        obs_t o;
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd6, 1'b1, 2'b10, 9, 4'b0001, 1'b0, -1, 1, o);
        n_cmp++; if (o.err_k !== 3 || o.done_n !== 0) begin n_fail++; $display("FAIL wrong_addr: err@%0d done=%0d want 3/0", o.err_k, o.done_n); end
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd6, 1'b1, 2'b10, 9, 4'b0001, 1'b0, 2, 2, o);
        n_cmp++; if (o.err_k !== 4 || o.done_n !== 0) begin n_fail++; $display("FAIL both_ack: err@%0d done=%0d want 4/0", o.err_k, o.done_n); end
        run_txn(rnd_vec(), rnd_vec(), '1, 5'd6, 1'b1, 2'b10, 9, 4'b0001, 1'b0, 0, -1, o);
        n_cmp++; if (o.done_k !== 2 || o.err_n !== 0) begin n_fail++; $display("FAIL ack_in_wr: done@%0d err=%0d want 2/0", o.done_k, o.err_n); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [DW-1:0] d, dst, exp;
        logic [VLEN-1:0] v0;
        logic [3:0] lm;
        logic [4:0] vd;
        logic vm, mdst;
        int r, regs, vl, sew, ack;
        bit legal;
        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 9);
            lm = (r < 2) ? 4'b0001 : (r < 4) ? 4'b0010 : (r < 6) ? 4'b0100 : (r < 8) ? 4'b1000 :
                 (r == 8) ? 4'b0011 : 4'b0000;
            regs = lmul_regs(lm);
            vd = 5'($urandom_range(0, 31));
            if (regs > 0 && $urandom_range(0, 4) != 0) vd = 5'((int'(vd) / regs) * regs);
            vm = 1'($urandom_range(0, 1));
            mdst = ($urandom_range(0, 5) == 0);
            vl = $urandom_range(0, 600);
            sew = $urandom_range(0, 3);
            ack = $urandom_range(0, 3);
            d = rnd_vec(); dst = rnd_vec(); v0 = rnd_vec()[VLEN-1:0];
            legal = model_legal(int'(vd), lm, vm, mdst);
            exp = model_wdata(d, dst, v0, vm, sew, vl, regs, mdst);
            run_txn(d, dst, v0, vd, vm, 2'(sew), vl, lm, mdst, ack, -1, o);
            if (legal) begin
                n_cmp++; if (o.wr_n !== (mdst ? 0 : 1) || o.mwr_n !== (mdst ? 1 : 0))
                         begin n_fail++; $display("FAIL rnd%0d_strobes: wr=%0d mwr=%0d mdst=%b", t, o.wr_n, o.mwr_n, mdst); end
                n_cmp++; if (o.wdata !== exp) begin n_fail++; $display("FAIL rnd%0d_wdata: first bad byte %0d", t, first_diff(o.wdata, exp)); end
                n_cmp++; if (o.done_k !== 2 + ack || o.err_n !== 0)
                         begin n_fail++; $display("FAIL rnd%0d_done: done@%0d err=%0d want done@%0d err=0", t, o.done_k, o.err_n, 2 + ack); end
            end else begin
                n_cmp++; if (o.err_k !== 1 || o.wr_n + o.mwr_n !== 0 || o.done_n !== 0)
                         begin n_fail++; $display("FAIL rnd%0d_illegal: err@%0d strobes=%0d done=%0d want 1/0/0", t, o.err_k, o.wr_n + o.mwr_n, o.done_n); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bound;
        int seen_done;
        @(negedge clk);
        res_data = rnd_vec(); res_vd = 5'd4; res_vm = 1'b1; res_sew = 2'b00; res_vl = VLW'(20);
        res_lmul = 4'b0001; res_mask_dst = 1'b0; res_valid = 1'b1;
        bound = 0;
        while (!res_ready && bound < 10) begin @(negedge clk); bound++; end
        @(posedge clk);
        @(negedge clk);
        res_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (rf_wr_en !== 1'b1) begin n_fail++; $display("FAIL rmid_in_wr: rf_wr_en=%b want 1", rf_wr_en); end
        reset = 1'b1;
        #1;
        n_cmp++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: rf_wr_en=%b want 0", rf_wr_en); end
        seen_done = 0;
        repeat (2) begin @(negedge clk); if (wb_done) seen_done++; end
        reset = 1'b0;
        repeat (3) begin @(negedge clk); if (wb_done) seen_done++; end
        n_cmp++; if (seen_done !== 0) begin n_fail++; $display("FAIL rmid_no_done: done pulses=%0d want 0", seen_done); end
        n_cmp++; if (res_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: ready=%b busy=%b want 1/0", res_ready, busy); end
        $display("txn %0d: reset during WR, wr_en after reset=%b", ++n_txn, rf_wr_en);
    endtask

    initial begin
        test_reset();
        test_unmasked();
        test_masked();
        test_illegal();
        test_mask_dst();
        test_vl_bounds();
        test_timeout();
        test_ack_variants();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
